// File: rtl/alarm_ctrl_if.sv
// Keypad/button inputs and display/load strobes between the alarm controller and its neighbours.
// Plain wires only: no flow control, every signal is sampled or driven each clock.
interface alarm_ctrl_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_new_time;
  logic       show_a;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  show_new_time, show_a, shift, load_new_a, load_new_c
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output show_new_time, show_a, shift, load_new_a, load_new_c
  );
endinterface

// File: rtl/alarm_ctrl_fsm.sv
// Alarm-clock sequencer: turns key/button activity into display and load strobes, with key-entry timeout.
// Moore outputs valid one cycle after the sampling edge; no backpressure, inputs are consumed every cycle.
module alarm_ctrl_fsm #(
  parameter logic [3:0] NOKEY       = 4'd10,
  parameter int         TIMEOUT_SEC = 10
) (
  input logic         clock,
  input logic         reset,
  alarm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_SHOW_TIME   = 3'd0,
    S_SHOW_ALARM  = 3'd1,
    S_KEY_STORED  = 3'd2,
    S_KEY_WAITED  = 3'd3,
    S_KEY_ENTRY   = 3'd4,
    S_SET_ALARM   = 3'd5,
    S_SET_CURRENT = 3'd6
  } state_e;

  localparam logic [3:0] TLAST = 4'(TIMEOUT_SEC - 1);

  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       key_pressed;
  logic       timeout;
  logic       win_q, win_d;

  assign key_pressed = (bus.key != NOKEY);
  assign timeout     = bus.one_second && (tcnt_q == TLAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SHOW_TIME;
      tcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = S_SHOW_TIME;
    case (state_q)
      S_SHOW_TIME: begin
        if (bus.alarm_button)  state_d = S_SHOW_ALARM;
        else if (key_pressed)  state_d = S_KEY_STORED;
        else                   state_d = S_SHOW_TIME;
      end
      S_SHOW_ALARM:  state_d = bus.alarm_button ? S_SHOW_ALARM : S_SHOW_TIME;
      S_KEY_STORED:  state_d = S_KEY_WAITED;
      S_KEY_WAITED: begin
        if (!key_pressed)      state_d = S_KEY_ENTRY;
        else if (timeout)      state_d = S_SHOW_TIME;
        else                   state_d = S_KEY_WAITED;
      end
      S_KEY_ENTRY: begin
        if (bus.alarm_button)     state_d = S_SET_ALARM;
        else if (bus.time_button) state_d = S_SET_CURRENT;
        else if (key_pressed)     state_d = S_KEY_STORED;
        else if (timeout)         state_d = S_SHOW_TIME;
        else                      state_d = S_KEY_ENTRY;
      end
      S_SET_ALARM:   state_d = S_SHOW_TIME;
      S_SET_CURRENT: state_d = S_SHOW_TIME;
      default:       state_d = S_SHOW_TIME;
    endcase
  end

  // Counter saturates at the last second so a release coinciding with the final tick cannot wrap it.
  assign win_q = (state_q == S_KEY_WAITED) || (state_q == S_KEY_ENTRY);
  assign win_d = (state_d == S_KEY_WAITED) || (state_d == S_KEY_ENTRY);

  always_comb begin
    tcnt_d = 4'd0;
    if (win_d && win_q) begin
      if (bus.one_second && (tcnt_q != TLAST)) tcnt_d = tcnt_q + 4'd1;
      else                                     tcnt_d = tcnt_q;
    end
  end

  always_comb begin
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.shift         = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    case (state_q)
      S_SHOW_ALARM:  bus.show_a = 1'b1;
      S_KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
      end
      S_KEY_WAITED:  bus.show_new_time = 1'b1;
      S_KEY_ENTRY:   bus.show_new_time = 1'b1;
      S_SET_ALARM:   bus.load_new_a    = 1'b1;
      S_SET_CURRENT: bus.load_new_c    = 1'b1;
      default: ;
    endcase
  end

endmodule
